// File: rtl/garage_pkg.sv
// rtl/garage_pkg.sv - state codes, direction constants and decode helper for the garage door sequencer
package garage_pkg;

    typedef enum logic [2:0] {
        STOPPED = 3'd0,
        CLOSED  = 3'd1,
        OPENING = 3'd2,
        OPEN    = 3'd3,
        CLOSING = 3'd4,
        DEAD    = 3'd5,
        FAULT   = 3'd6
    } door_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic logic state_is_busy(input door_state_t s);
        return (s == OPENING) || (s == CLOSING) || (s == DEAD);
    endfunction

endpackage

// File: rtl/garage_cycle_timer.sv
// rtl/garage_cycle_timer.sv - loadable down-counter that holds at zero, shared by all timed door states
module garage_cycle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/garage_door_sequencer.sv
// rtl/garage_door_sequencer.sv - garage door motor sequencer; GARAGE_AUTO_CLOSE_EN enables the timed auto-close from OPEN
module garage_door_sequencer
    import garage_pkg::*;
#(
    parameter int DEAD_TIME        = 4,
    parameter int TRAVEL_TIMEOUT   = 1000,
    parameter int AUTO_CLOSE_DELAY = 500,
    parameter int CNT_W            = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_wall,
    input  logic       btn_remote,
    input  logic       obstruct,
    input  logic       UP_Max,
    input  logic       DN_Max,
    output logic       UP_M,
    output logic       DN_M,
    output logic       fault,
    output logic       busy,
    output logic [2:0] door_state
);

    if (DEAD_TIME < 1 || DEAD_TIME >= (1 << CNT_W)) begin : g_bad_dead_time
        $error("DEAD_TIME out of range");
    end
    if (TRAVEL_TIMEOUT < 2 || TRAVEL_TIMEOUT >= (1 << CNT_W)) begin : g_bad_travel_timeout
        $error("TRAVEL_TIMEOUT out of range");
    end
    if (AUTO_CLOSE_DELAY < 1 || AUTO_CLOSE_DELAY >= (1 << CNT_W)) begin : g_bad_auto_close
        $error("AUTO_CLOSE_DELAY out of range");
    end

    door_state_t      state_q, state_d;
    logic             dir_last_q, dir_last_d;
    logic             target_q, target_d;
    logic             wall_q, remote_q;
    logic             req, both_limits;
    logic             tmr_expired, tmr_load, open_hold;
    logic [CNT_W-1:0] tmr_val;

    assign req         = (btn_wall & ~wall_q) | (btn_remote & ~remote_q);
    assign both_limits = UP_Max & DN_Max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= STOPPED;
            dir_last_q <= DIR_UP;
            target_q   <= DIR_DN;
            wall_q     <= 1'b0;
            remote_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_last_q <= dir_last_d;
            target_q   <= target_d;
            wall_q     <= btn_wall;
            remote_q   <= btn_remote;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_last_d = dir_last_q;
        target_d   = target_q;
        open_hold  = 1'b0;
        if (both_limits) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                STOPPED: begin
                    if (DN_Max) begin
                        state_d = CLOSED;
                    end else if (UP_Max) begin
                        state_d = OPEN;
                    end else if (req) begin
                        state_d  = DEAD;
                        target_d = ~dir_last_q;
                    end
                end
                CLOSED: begin
                    if (req) begin
                        state_d    = OPENING;
                        dir_last_d = DIR_UP;
                    end
                end
                OPEN: begin
                    if (req) begin
                        state_d    = CLOSING;
                        dir_last_d = DIR_DN;
                    end
`ifdef GARAGE_AUTO_CLOSE_EN
                    // A blocked beam keeps restarting the auto-close delay.
                    else if (obstruct) begin
                        open_hold = 1'b1;
                    end else if (tmr_expired) begin
                        state_d    = CLOSING;
                        dir_last_d = DIR_DN;
                    end
`endif
                end
                OPENING: begin
                    if (UP_Max) begin
                        state_d = OPEN;
                    end else if (req) begin
                        state_d    = STOPPED;
                        dir_last_d = DIR_UP;
                    end else if (tmr_expired) begin
                        state_d = FAULT;
                    end
                end
                CLOSING: begin
                    if (DN_Max) begin
                        state_d = CLOSED;
                    end else if (obstruct) begin
                        state_d  = DEAD;
                        target_d = DIR_UP;
                    end else if (req) begin
                        state_d    = STOPPED;
                        dir_last_d = DIR_DN;
                    end else if (tmr_expired) begin
                        state_d = FAULT;
                    end
                end
                DEAD: begin
                    if (obstruct) begin
                        target_d = DIR_UP;
                    end
                    if (tmr_expired) begin
                        state_d    = target_d ? OPENING : CLOSING;
                        dir_last_d = target_d;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = FAULT;
                end
            endcase
        end
    end

    // Reload with N-1 on entry so the state lasts exactly N cycles.
    always_comb begin
        tmr_val = '0;
        case (state_d)
            DEAD:             tmr_val = CNT_W'(DEAD_TIME - 1);
            OPENING, CLOSING: tmr_val = CNT_W'(TRAVEL_TIMEOUT - 1);
`ifdef GARAGE_AUTO_CLOSE_EN
            OPEN:             tmr_val = CNT_W'(AUTO_CLOSE_DELAY - 1);
`endif
            default:          tmr_val = '0;
        endcase
    end

    assign tmr_load = (state_d != state_q) || open_hold;

    garage_cycle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expired (tmr_expired)
    );

    assign UP_M       = (state_q == OPENING);
    assign DN_M       = (state_q == CLOSING);
    assign fault      = (state_q == FAULT);
    assign busy       = state_is_busy(state_q);
    assign door_state = state_q;

endmodule

// File: tb/tb_garage_door_sequencer.sv
// tb/tb_garage_door_sequencer.sv - directed and randomized checks of garage_door_sequencer against a cycle-age reference model
module tb_garage_door_sequencer;
    import garage_pkg::*;

    localparam int DT = 4;
    localparam int TT = 20;
    localparam int AC = 10;
`ifdef GARAGE_AUTO_CLOSE_EN
    localparam bit AC_ON = 1'b1;
`else
    localparam bit AC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, btn_wall, btn_remote, obstruct, UP_Max, DN_Max;
    logic       UP_M, DN_M, fault, busy;
    logic [2:0] door_state;

    int total = 0;
    int bad   = 0;

    // Reference model: tracks the cycle each state was entered and measures age by subtraction.
    door_state_t m_st = STOPPED;
    int          cyc = 0, m_entered = 0, m_ref = 0;
    bit          m_dir_up = 1'b1, m_tgt_up = 1'b0, m_wall_prev = 1'b0, m_rem_prev = 1'b0;

    always #5 clk = ~clk;

    garage_door_sequencer #(
        .DEAD_TIME       (DT),
        .TRAVEL_TIMEOUT  (TT),
        .AUTO_CLOSE_DELAY(AC),
        .CNT_W           (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_wall  (btn_wall),
        .btn_remote(btn_remote),
        .obstruct  (obstruct),
        .UP_Max    (UP_Max),
        .DN_Max    (DN_Max),
        .UP_M      (UP_M),
        .DN_M      (DN_M),
        .fault     (fault),
        .busy      (busy),
        .door_state(door_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int          age, ref_age;
        bit          req_m;
        door_state_t nst;
        if (rst) begin
            m_st        = STOPPED;
            m_dir_up    = 1'b1;
            m_wall_prev = 1'b0;
            m_rem_prev  = 1'b0;
            m_entered   = cyc + 1;
            m_ref       = cyc + 1;
            cyc++;
            return;
        end
        req_m   = (btn_wall && !m_wall_prev) || (btn_remote && !m_rem_prev);
        age     = cyc - m_entered + 1;
        ref_age = cyc - m_ref + 1;
        nst     = m_st;
        if (UP_Max && DN_Max) begin
            nst = FAULT;
        end else begin
            case (m_st)
                STOPPED: begin
                    if (DN_Max) nst = CLOSED;
                    else if (UP_Max) nst = OPEN;
                    else if (req_m) begin
                        nst      = DEAD;
                        m_tgt_up = !m_dir_up;
                    end
                end
                CLOSED:  if (req_m) nst = OPENING;
                OPEN: begin
                    if (req_m) nst = CLOSING;
                    else if (AC_ON && !obstruct && ref_age >= AC) nst = CLOSING;
                end
                OPENING: begin
                    if (UP_Max) nst = OPEN;
                    else if (req_m) nst = STOPPED;
                    else if (age >= TT) nst = FAULT;
                end
                CLOSING: begin
                    if (DN_Max) nst = CLOSED;
                    else if (obstruct) begin
                        nst      = DEAD;
                        m_tgt_up = 1'b1;
                    end else if (req_m) nst = STOPPED;
                    else if (age >= TT) nst = FAULT;
                end
                DEAD: begin
                    if (obstruct) m_tgt_up = 1'b1;
                    if (age >= DT) nst = m_tgt_up ? OPENING : CLOSING;
                end
                default: nst = m_st;
            endcase
        end
        m_wall_prev = btn_wall;
        m_rem_prev  = btn_remote;
        if (nst != m_st) begin
            m_entered = cyc + 1;
            m_ref     = cyc + 1;
        end else if (m_st == OPEN && obstruct) begin
            m_ref = cyc + 1;
        end
        if (nst == OPENING) m_dir_up = 1'b1;
        if (nst == CLOSING) m_dir_up = 1'b0;
        m_st = nst;
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_state", 32'(door_state), 32'(m_st));
        chk("model_up_m", 32'(UP_M), 32'(m_st == OPENING));
        chk("model_dn_m", 32'(DN_M), 32'(m_st == CLOSING));
        chk("model_fault", 32'(fault), 32'(m_st == FAULT));
        chk("model_busy", 32'(busy), 32'(m_st == OPENING || m_st == CLOSING || m_st == DEAD));
        chk("motor_excl", 32'(UP_M & DN_M), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; btn_wall = 1'b0; btn_remote = 1'b0; obstruct = 1'b0;
        UP_Max = 1'b0; DN_Max = 1'b1;

        // Reset state, resolve to CLOSED, open to the upper limit
        tick(); tick();
        chk("rst_state", 32'(door_state), 32'd0);
        chk("rst_motors", 32'({UP_M, DN_M, fault, busy}), 32'd0);
        rst = 1'b0;
        tick();
        chk("closed_after_rst", 32'(door_state), 32'(CLOSED));
        btn_wall = 1'b1;
        tick();
        chk("wall_up_m", 32'(UP_M), 32'd1);
        DN_Max = 1'b0;
        tick(); tick(); tick();
        UP_Max = 1'b1;
        tick();
        chk("limit_up_m_off", 32'(UP_M), 32'd0);
        chk("limit_open", 32'(door_state), 32'(OPEN));
        btn_wall = 1'b0;

        // Close, obstruct, dead time, reverse
        btn_remote = 1'b1;
        tick();
        chk("close_dn_m", 32'(DN_M), 32'd1);
        btn_remote = 1'b0; UP_Max = 1'b0;
        tick(); tick();
        obstruct = 1'b1;
        tick();
        chk("obst_dn_m_off", 32'(DN_M), 32'd0);
        chk("obst_dead", 32'(door_state), 32'(DEAD));
        obstruct = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("obst_dead_hold", 32'(door_state), 32'(DEAD));
        end
        tick();
        chk("reverse_up_m", 32'(UP_M), 32'd1);

        // Travel watchdog
        n = 1;
        while (UP_M === 1'b1 && n < 40) begin
            tick();
            if (UP_M === 1'b1) n++;
        end
        chk("travel_len", 32'(n), 32'(TT));
        chk("timeout_fault", 32'(fault), 32'd1);
        chk("timeout_state", 32'(door_state), 32'(FAULT));
        btn_wall = 1'b1; btn_remote = 1'b1;
        tick();
        btn_wall = 1'b0; btn_remote = 1'b0;
        tick();
        chk("fault_sticky", 32'(door_state), 32'(FAULT));
        rst = 1'b1;
        tick();
        chk("rst_clears_fault", 32'(fault), 32'd0);
        rst = 1'b0;

        // Stop mid-close, resume with reversal, coincident edges
        tick();
        chk("idle_stopped", 32'(door_state), 32'(STOPPED));
        btn_wall = 1'b1;
        tick();
        chk("stop_req_dead", 32'(door_state), 32'(DEAD));
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("first_move_close", 32'(door_state), 32'(CLOSING));
        btn_wall = 1'b0;
        tick();
        btn_wall = 1'b1; btn_remote = 1'b1;
        tick();
        chk("coincident_stop", 32'(door_state), 32'(STOPPED));
        tick();
        chk("held_no_req", 32'(door_state), 32'(STOPPED));
        btn_wall = 1'b0; btn_remote = 1'b0;
        tick();
        btn_remote = 1'b1;
        tick();
        chk("resume_dead", 32'(door_state), 32'(DEAD));
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("resume_opening", 32'(door_state), 32'(OPENING));
        btn_remote = 1'b0;

        // Auto-close behaviour in OPEN
        rst = 1'b1; UP_Max = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("open_from_rst", 32'(door_state), 32'(OPEN));
`ifdef GARAGE_AUTO_CLOSE_EN
        for (int i = 0; i < AC - 1; i++) tick();
        chk("ac_still_open", 32'(door_state), 32'(OPEN));
        tick();
        chk("ac_dn_m", 32'(DN_M), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        obstruct = 1'b1;
        tick(); tick(); tick();
        obstruct = 1'b0;
        for (int i = 0; i < AC - 1; i++) tick();
        chk("ac_obst_open", 32'(door_state), 32'(OPEN));
        tick();
        chk("ac_obst_dn_m", 32'(DN_M), 32'd1);
`else
        obstruct = 1'b1;
        tick();
        obstruct = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("no_ac_open", 32'(door_state), 32'(OPEN));
`endif

        // Both limits while closing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        UP_Max = 1'b0;
        btn_wall = 1'b1;
        tick();
        chk("bl_closing", 32'(door_state), 32'(CLOSING));
        btn_wall = 1'b0; UP_Max = 1'b1; DN_Max = 1'b1;
        tick();
        chk("bl_fault", 32'(fault), 32'd1);
        chk("bl_motors_off", 32'({UP_M, DN_M}), 32'd0);

        // Randomized traffic against the model
        rst = 1'b1; UP_Max = 1'b0; DN_Max = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) btn_wall = ~btn_wall;
            if ($urandom_range(0, 7) == 0) btn_remote = ~btn_remote;
            obstruct = ($urandom_range(0, 9) == 0);
            UP_Max   = ($urandom_range(0, 19) == 0);
            DN_Max   = ($urandom_range(0, 19) == 0);
            rst      = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/garage_door_sequencer.md
# garage_door_sequencer

Top-level sequencer for the garage door motor drive. It merges the wall button and the remote into one request stream and runs the door through open, close, stop and reverse sequences. It enforces a dead time before any direction reversal, a travel-time watchdog and obstruction reversal, and drives the UP_M/DN_M motor enables consumed by the motor driver stage.

## Interface
- DEAD_TIME, 4: motor-off cycles inserted before any move that follows a stop or reversal (≥1).
- TRAVEL_TIMEOUT, 1000: maximum cycles in OPENING/CLOSING before a fault is declared (≥2).
- AUTO_CLOSE_DELAY, 500: cycles spent in OPEN before an automatic close (only with the macro).
- CNT_W, 16: timer width; each of the three counts above must fit in CNT_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- btn_wall  in  1  wall push-button, level, already synchronised upstream.
- btn_remote  in  1  remote receiver pulse/level, already synchronised.
- obstruct  in  1  photo-beam blocked, level.
- UP_Max  in  1  fully-open limit switch.
- DN_Max  in  1  fully-closed limit switch.
- UP_M  out  1  motor-up enable.
- DN_M  out  1  motor-down enable.
- fault  out  1  sticky fault flag.
- busy  out  1  high in OPENING, CLOSING or DEAD.
- door_state  out  3  current state code.

## Operation
- Request generation: each button is edge-detected via a registered copy; `req = (btn_wall & ~wall_q) | (btn_remote & ~remote_q)`. Coincident edges count as one request. A held button produces no further requests.
- The one-bit `dir_last` records the last travel direction.
- States and transitions:
  - STOPPED (reset state): UP_Max&DN_Max → FAULT; DN_Max → CLOSED; UP_Max → OPEN; otherwise req → DEAD with target opposite of dir_last.
  - CLOSED: req → OPENING.
  - OPEN: req → CLOSING; auto-close expiry → CLOSING.
  - OPENING / CLOSING: evaluated in priority order:
    1. UP_Max&DN_Max → FAULT.
    2. Own limit (UP_Max / DN_Max) → OPEN / CLOSED.
    3. CLOSING with obstruct → DEAD, target OPENING.
    4. req → STOPPED, dir_last updated.
    5. Timer expiry → FAULT.
  - DEAD: both motors off for DEAD_TIME cycles, then → target. obstruct while the target is CLOSING forces the target to OPENING.
  - FAULT: motors off, fault=1; left only by rst.
- Both limits high in any state → FAULT.
- obstruct is ignored in OPENING.
- Motor outputs are a Moore decode of state: UP_M=1 only in OPENING, DN_M=1 only in CLOSING. UP_M&DN_M never equals 1.
- Arithmetic: the single down-counter is reloaded with N-1 on state entry; expiry occurs when it reaches 0 while still in the state, giving exactly N cycles of residence. There is no wrap-around: the counter holds at 0.

## Timing
- Reset values: UP_M=0, DN_M=0, fault=0, busy=0, door_state=STOPPED, dir_last=UP, wall_q=remote_q=0, timer=0.
- A button edge sampled at cycle n produces the state change and the motor output at cycle n+1.
- A limit, obstruct or both-limits condition at cycle n turns the motor off at cycle n+1.
- Reversal on obstruction: DN_M drops at n+1 and UP_M rises at n+1+DEAD_TIME.
- rst mid-travel: motors off on the next edge; then the reset values apply, followed by limit resolution from STOPPED.

## Configuration
- GARAGE_AUTO_CLOSE_EN defined: OPEN loads AUTO_CLOSE_DELAY-1 on entry. obstruct high in OPEN reloads the timer. Expiry → CLOSING.
- GARAGE_AUTO_CLOSE_EN undefined: OPEN waits indefinitely for req, AUTO_CLOSE_DELAY is unused, and no auto-close logic is synthesised.

## Structure
- Package garage_pkg holds:
  - the state codes: STOPPED=3'd0, CLOSED=3'd1, OPENING=3'd2, OPEN=3'd3, CLOSING=3'd4, DEAD=3'd5, FAULT=3'd6;
  - the direction constants DIR_UP=1'b1, DIR_DN=1'b0.
- Sub-module garage_cycle_timer: loadable CNT_W down-counter with an expiry flag. It is shared for dead-time, travel and auto-close counts, since those states are mutually exclusive.

## Test plan
Parameters for all scenarios: DEAD_TIME=4, TRAVEL_TIMEOUT=20, AUTO_CLOSE_DELAY=10.
- Reset with DN_Max=1 → door_state=CLOSED at cycle 1. Wall edge → UP_M=1 the next cycle. UP_Max at cycle k → UP_M=0, door_state=OPEN at k+1.
- CLOSING with obstruct pulsed → DN_M=0 next cycle, DEAD for 4 cycles, then UP_M=1. No cycle has UP_M=DN_M=1.
- OPENING with no limit → UP_M high exactly 20 cycles, then fault=1, door_state=FAULT. Later requests are ignored; rst clears the fault.
- Mid-close request → STOPPED. Second request → 4 DEAD cycles, then OPENING. Wall and remote edges in the same cycle → a single transition.
- With GARAGE_AUTO_CLOSE_EN in OPEN → DN_M=1 after 10 cycles; obstruct at cycle 5 delays the close to 10 cycles after obstruct falls. Without the macro → still OPEN after 100 cycles.
- Both UP_Max and DN_Max high during CLOSING → fault=1, motors off the next cycle.
